// File: rtl/rtc_bus_pkg.sv
// rtc_bus_pkg: FSM states, default phase timing and RTC register map shared by the RTC bus access block.
package rtc_bus_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_ADDR_SETUP, S_ADDR_STROBE, S_ADDR_HOLD,
    S_DATA_SETUP, S_DATA_STROBE, S_DATA_HOLD, S_DONE, S_GAP
  } state_t;
  localparam int unsigned DEF_SETUP  = 2;
  localparam int unsigned DEF_STROBE = 4;
  localparam int unsigned DEF_HOLD   = 2;
  localparam int unsigned DEF_GAP    = 4;
  localparam logic [7:0] RTC_CMD_READ_XFER  = 8'hF0;
  localparam logic [7:0] RTC_CMD_RAM_TO_CLK = 8'hF1;
  localparam logic [7:0] RTC_CMD_TIMER_XFER = 8'hF2;
  localparam logic [7:0] RTC_SECONDS  = 8'h21;
  localparam logic [7:0] RTC_MINUTES  = 8'h22;
  localparam logic [7:0] RTC_HOURS    = 8'h23;
  localparam logic [7:0] RTC_DAY      = 8'h24;
  localparam logic [7:0] RTC_MONTH    = 8'h25;
  localparam logic [7:0] RTC_YEAR     = 8'h26;
  localparam logic [7:0] RTC_WEEKDAY  = 8'h27;
  localparam logic [7:0] RTC_TMR_SEC  = 8'h41;
  localparam logic [7:0] RTC_TMR_MIN  = 8'h42;
  localparam logic [7:0] RTC_TMR_HOUR = 8'h43;
endpackage

// File: rtl/rtc_bus_phase_timer.sv
// rtc_bus_phase_timer: 8-bit loadable down-counter; o_zero flags the last cycle of a phase.
module rtc_bus_phase_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic [7:0] i_val,
  output logic       o_zero
);
  logic [7:0] r_cnt;
  always_ff @(posedge clk) begin
    if (reset) r_cnt <= 8'd0;
    else if (i_load) r_cnt <= i_val;
    else if (r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
  end
  assign o_zero = (r_cnt == 8'd0);
endmodule

// File: rtl/rtc_bus_access.sv
// rtc_bus_access: executes one multiplexed address/data RTC bus access per sequencer request.
// Optional transaction counter output enabled by RTC_BUS_ACCESS_TXN_COUNT_EN.
module rtc_bus_access
  import rtc_bus_pkg::*;
#(
  parameter int unsigned P_SETUP  = DEF_SETUP,
  parameter int unsigned P_STROBE = DEF_STROBE,
  parameter int unsigned P_HOLD   = DEF_HOLD,
  parameter int unsigned P_GAP    = DEF_GAP
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_en_funcion_rtc,
  input  logic       in_funcion_w_r,
  input  logic [7:0] in_addr_ram_rtc,
  input  logic [7:0] in_dato,
  input  logic [7:0] in_ad_bus,
  output logic [7:0] out_ad_bus,
  output logic       out_ad_oe,
  output logic       out_cs_n,
  output logic       out_ad_n,
  output logic       out_rd_n,
  output logic       out_wr_n,
  output logic       out_flag_done,
  output logic [7:0] out_dato_leido,
`ifdef RTC_BUS_ACCESS_TXN_COUNT_EN
  output logic [15:0] out_txn_count,
`endif
  output logic       out_ocupado
);
  state_t     r_state, w_next;
  logic       r_wr;
  logic [7:0] r_addr, r_dato, w_len;
  logic       w_zero, w_addr_ph, w_data_ph, w_strobe, w_rd_n, w_wr_n;
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = in_en_funcion_rtc ? S_ADDR_SETUP : S_IDLE;
      S_GAP:   w_next = w_zero ? S_IDLE : S_GAP;
      default: w_next = w_zero ? state_t'(r_state + 4'd1) : r_state;
    endcase
    w_len = (w_next inside {S_ADDR_SETUP, S_DATA_SETUP})   ? 8'(P_SETUP)  :
            (w_next inside {S_ADDR_STROBE, S_DATA_STROBE}) ? 8'(P_STROBE) :
            (w_next inside {S_ADDR_HOLD, S_DATA_HOLD})     ? 8'(P_HOLD)   :
            (w_next == S_GAP)                              ? 8'(P_GAP)    : 8'd1;
  end
  rtc_bus_phase_timer u_timer (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_next != r_state),
    .i_val  (w_len - 8'd1),
    .o_zero (w_zero)
  );
  assign w_addr_ph = r_state inside {S_ADDR_SETUP, S_ADDR_STROBE, S_ADDR_HOLD};
  assign w_data_ph = r_state inside {S_DATA_SETUP, S_DATA_STROBE, S_DATA_HOLD};
  assign w_strobe  = r_state inside {S_ADDR_STROBE, S_DATA_STROBE};
  assign w_rd_n    = !(r_state == S_DATA_STROBE && !r_wr);
  assign w_wr_n    = !(r_state == S_ADDR_STROBE || (r_state == S_DATA_STROBE && r_wr));
  // Outputs are decoded from the current state and registered, so they trail the state by one edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr           <= 1'b0;
      r_addr         <= 8'h00;
      r_dato         <= 8'h00;
      out_ad_bus     <= 8'h00;
      out_ad_oe      <= 1'b0;
      out_cs_n       <= 1'b1;
      out_ad_n       <= 1'b1;
      out_rd_n       <= 1'b1;
      out_wr_n       <= 1'b1;
      out_flag_done  <= 1'b0;
      out_ocupado    <= 1'b0;
      out_dato_leido <= 8'h00;
    end else begin
      if (r_state == S_IDLE && in_en_funcion_rtc) begin
        r_wr   <= in_funcion_w_r;
        r_addr <= in_addr_ram_rtc;
        r_dato <= in_dato;
      end
      out_ad_bus    <= w_addr_ph ? r_addr : (w_data_ph && r_wr) ? r_dato : 8'h00;
      out_ad_oe     <= w_addr_ph || (w_data_ph && r_wr);
      out_cs_n      <= !w_strobe;
      out_ad_n      <= !w_addr_ph;
      out_rd_n      <= w_rd_n;
      out_wr_n      <= w_wr_n;
      out_flag_done <= (r_state == S_DONE);
      out_ocupado   <= (r_state != S_IDLE);
      // Capture on the edge where the visible read strobe rises.
      if (!out_rd_n && w_rd_n) out_dato_leido <= in_ad_bus;
    end
  end
`ifdef RTC_BUS_ACCESS_TXN_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) out_txn_count <= 16'h0000;
    else if (r_state == S_DONE) out_txn_count <= out_txn_count + 16'h0001;
  end
`endif
endmodule
